conv_mac_engine: RTL and testbench

//  Parametrised successor to the fixed 4-lane MAC/accumulator/out-buffer path of the conv accelerator.

---
 rtl/conv_pkg.sv | 19 +
 rtl/conv_mac_engine_if.sv | 34 +++
 rtl/conv_lane_tree.sv | 60 ++++++
 rtl/conv_mac_engine.sv | 161 ++++++++++++++++
 tb/tb_conv_mac_engine.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared types and default sizes for the conv MAC engine slice.
package conv_pkg;

    localparam int LANES_DEF = 4;
    localparam int DW_DEF    = 16;
    localparam int ACCW_DEF  = 32;
    localparam int AW_DEF    = 16;

    typedef enum logic [2:0] {
        IDLE,
        ACC,
        DRAIN,
        PSUM_RD,
        PSUM_ADD,
        WRITE,
        DONE
    } state_t;

endpackage

// File: rtl/conv_mac_engine_if.sv
// Beat stream, psum read port and result write port of the conv MAC engine.
// master: the feeding/sinking environment; slave: the engine itself.
interface conv_mac_engine_if #(
    parameter int LANES = conv_pkg::LANES_DEF,
    parameter int DW    = conv_pkg::DW_DEF,
    parameter int ACCW  = conv_pkg::ACCW_DEF,
    parameter int AW    = conv_pkg::AW_DEF
);

    logic                  in_valid;
    logic                  in_ready;
    logic [LANES*DW-1:0]   in_ifm;
    logic [LANES*DW-1:0]   in_w;

    logic                  psum_rd_en;
    logic [AW-1:0]         psum_rd_addr;
    logic [ACCW-1:0]       psum_rd_data;

    logic                  out_valid;
    logic                  out_ready;
    logic [AW-1:0]         out_addr;
    logic [ACCW-1:0]       out_data;

    modport master (
        output in_valid, in_ifm, in_w, psum_rd_data, out_ready,
        input  in_ready, psum_rd_en, psum_rd_addr, out_valid, out_addr, out_data
    );

    modport slave (
        input  in_valid, in_ifm, in_w, psum_rd_data, out_ready,
        output in_ready, psum_rd_en, psum_rd_addr, out_valid, out_addr, out_data
    );

endinterface

// File: rtl/conv_lane_tree.sv
// Registered LANES-way signed multiply followed by a combinational lane-sum,
// sign-extended to the accumulator width. Lane 0 sits in the operand MSBs.
module conv_lane_tree #(
    parameter int LANES = conv_pkg::LANES_DEF,
    parameter int DW    = conv_pkg::DW_DEF,
    parameter int ACCW  = conv_pkg::ACCW_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     vld_p0,
    input  logic                     first_p0,
    input  logic [LANES*DW-1:0]      ifm_p0,
    input  logic [LANES*DW-1:0]      w_p0,
    output logic                     vld_p1,
    output logic                     first_p1,
    output logic signed [ACCW-1:0]   sum_p1
);

    logic signed [DW-1:0]   ifm_lane [LANES];
    logic signed [DW-1:0]   w_lane   [LANES];
    logic signed [2*DW-1:0] prod_p1  [LANES];

    // Unpack the beat words into signed lanes.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            ifm_lane[i] = ifm_p0[(LANES-1-i)*DW +: DW];
            w_lane[i]   = w_p0[(LANES-1-i)*DW +: DW];
        end
    end

    // ---- stage 1: product registers ----
    // Valid and first-beat tag travel with the products.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            first_p1 <= 1'b0;
        end else begin
            vld_p1   <= vld_p0;
            first_p1 <= first_p0;
        end
    end

    // Capture the full-precision lane products of an accepted beat.
    always_ff @(posedge clk) begin
        if (vld_p0) begin
            for (int i = 0; i < LANES; i++) begin
                prod_p1[i] <= (2*DW)'(ifm_lane[i]) * (2*DW)'(w_lane[i]);
            end
        end
    end

    // ---- stage 2 input: lane sum, sign-extended, wrapping ----
    always_comb begin
        sum_p1 = '0;
        for (int i = 0; i < LANES; i++) begin
            sum_p1 = sum_p1 + ACCW'(prod_p1[i]);
        end
    end

endmodule

// File: rtl/conv_mac_engine.sv
// Conv MAC engine: per-neuron LANES-wide dot product, partial-sum fold-in
// from the output RAM and result write-back, sequenced by cfg_start/done.
// Optional build macro CONV_MAC_RELU_EN clamps negative results to 0 on the
// final tile (cfg_last_pass=1); without it cfg_last_pass has no effect.
module conv_mac_engine
    import conv_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int DW    = DW_DEF,
    parameter int ACCW  = ACCW_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_start,
    input  logic [15:0]           cfg_dot_len,
    input  logic [AW-1:0]         cfg_num_out,
    input  logic [AW-1:0]         cfg_base_addr,
    input  logic                  cfg_first_pass,
    input  logic                  cfg_last_pass,
    output logic                  busy,
    output logic                  done,
    conv_mac_engine_if.slave      bus
);

    state_t                 state_q, state_d;
    logic [15:0]            dot_len_q, beat_cnt;
    logic [AW-1:0]          num_out_q, base_q, neuron_cnt;
    logic                   first_q, drain_cnt;
    logic                   in_ready_c, psum_rd_en_c, out_valid_c;
    logic                   beat_fire, last_beat, last_neuron, start_ok;
    logic                   vld_p1, first_p1;
    logic signed [ACCW-1:0] sum_p1, acc_p2;

`ifdef CONV_MAC_RELU_EN
    logic                   last_q;

    function automatic logic signed [ACCW-1:0] post_op(input logic signed [ACCW-1:0] a,
                                                       input logic last);
        return (last && a[ACCW-1]) ? '0 : a;
    endfunction
`else
    logic                   unused_last;
    assign unused_last = cfg_last_pass;

    function automatic logic signed [ACCW-1:0] post_op(input logic signed [ACCW-1:0] a);
        return a;
    endfunction
`endif

    assign start_ok    = (state_q == IDLE) && cfg_start;
    assign beat_fire   = in_ready_c && bus.in_valid;
    assign last_beat   = (beat_cnt == dot_len_q - 16'd1);
    assign last_neuron = (neuron_cnt == num_out_q - AW'(1));

    conv_lane_tree #(.LANES(LANES), .DW(DW), .ACCW(ACCW)) u_tree (
        .clk      (clk),
        .rst_n    (rst_n),
        .vld_p0   (beat_fire),
        .first_p0 (beat_cnt == 16'd0),
        .ifm_p0   (bus.in_ifm),
        .w_p0     (bus.in_w),
        .vld_p1   (vld_p1),
        .first_p1 (first_p1),
        .sum_p1   (sum_p1)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d      = state_q;
        in_ready_c   = 1'b0;
        psum_rd_en_c = 1'b0;
        out_valid_c  = 1'b0;
        done         = 1'b0;
        busy         = (state_q != IDLE);
        case (state_q)
            IDLE:     if (cfg_start) state_d = (cfg_num_out == '0) ? DONE : ACC;
            ACC: begin
                in_ready_c = 1'b1;
                if (bus.in_valid && last_beat) state_d = DRAIN;
            end
            // Two cycles: products land in stage 1, then fold into acc.
            DRAIN:    if (drain_cnt) state_d = first_q ? PSUM_ADD : PSUM_RD;
            PSUM_RD: begin
                psum_rd_en_c = 1'b1;
                state_d      = PSUM_ADD;
            end
            PSUM_ADD: state_d = WRITE;
            WRITE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) state_d = last_neuron ? DONE : ACC;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default:  state_d = IDLE;
        endcase
    end

    // Pass configuration latch and beat/neuron/drain counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dot_len_q  <= '0;
            num_out_q  <= '0;
            base_q     <= '0;
            first_q    <= 1'b0;
            beat_cnt   <= '0;
            neuron_cnt <= '0;
            drain_cnt  <= 1'b0;
`ifdef CONV_MAC_RELU_EN
            last_q     <= 1'b0;
`endif
        end else begin
            if (start_ok) begin
                dot_len_q  <= (cfg_dot_len == 16'd0) ? 16'd1 : cfg_dot_len;
                num_out_q  <= cfg_num_out;
                base_q     <= cfg_base_addr;
                first_q    <= cfg_first_pass;
                beat_cnt   <= '0;
                neuron_cnt <= '0;
`ifdef CONV_MAC_RELU_EN
                last_q     <= cfg_last_pass;
`endif
            end
            if (beat_fire) beat_cnt <= last_beat ? 16'd0 : beat_cnt + 16'd1;
            drain_cnt <= (state_q == DRAIN) ? ~drain_cnt : 1'b0;
            if (state_q == WRITE && bus.out_ready && !last_neuron)
                neuron_cnt <= neuron_cnt + AW'(1);
        end
    end

    // ---- stage 2: accumulator (clears on a neuron's first beat) and psum fold-in ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_p2 <= '0;
        end else if (vld_p1) begin
            acc_p2 <= (first_p1 ? '0 : acc_p2) + sum_p1;
        end else if (state_q == PSUM_ADD && !first_q) begin
            acc_p2 <= acc_p2 + $signed(bus.psum_rd_data);
        end
    end

    assign bus.in_ready     = in_ready_c;
    assign bus.psum_rd_en   = psum_rd_en_c;
    assign bus.out_valid    = out_valid_c;
    assign bus.out_addr     = base_q + neuron_cnt;
    assign bus.psum_rd_addr = base_q + neuron_cnt;
`ifdef CONV_MAC_RELU_EN
    assign bus.out_data     = post_op(acc_p2, last_q);
`else
    assign bus.out_data     = post_op(acc_p2);
`endif

endmodule

// File: tb/tb_conv_mac_engine.sv
// Directed bench for conv_mac_engine: single/multi-neuron passes, psum
// fold-in, back-pressure, ignored restart, empty pass, post-op and reset abort.
module tb_conv_mac_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_start;
    logic [15:0] cfg_dot_len;
    logic [15:0] cfg_num_out;
    logic [15:0] cfg_base_addr;
    logic        cfg_first_pass;
    logic        cfg_last_pass;
    logic        busy;
    logic        done;

    int          n_asserts = 0;
    int          n_fail    = 0;

    logic [31:0] psum_val;
    logic [15:0] wr_addr [16];
    logic [31:0] wr_data [16];
    int          wr_n;
    int          rd_n;
    logic [15:0] rd_addr;
    int          beat_n;
    int          done_n;

    conv_mac_engine_if #(.LANES(4), .DW(16), .ACCW(32), .AW(16)) bus ();

    conv_mac_engine dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_start      (cfg_start),
        .cfg_dot_len    (cfg_dot_len),
        .cfg_num_out    (cfg_num_out),
        .cfg_base_addr  (cfg_base_addr),
        .cfg_first_pass (cfg_first_pass),
        .cfg_last_pass  (cfg_last_pass),
        .busy           (busy),
        .done           (done),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    // Psum RAM model: data only valid the cycle after the read strobe.
    always @(posedge clk) begin
        bus.psum_rd_data <= bus.psum_rd_en ? psum_val : 32'hDEAD_BEEF;
    end

    // Transfer monitor, sampled mid-cycle for the coming edge.
    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready && wr_n < 16) begin
            wr_addr[wr_n] = bus.out_addr;
            wr_data[wr_n] = bus.out_data;
            wr_n++;
        end
        if (bus.psum_rd_en) begin
            rd_n++;
            rd_addr = bus.psum_rd_addr;
        end
        if (bus.in_valid && bus.in_ready) beat_n++;
        if (done) done_n++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_asserts++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] pack(input int a, input int b, input int c, input int d);
        return {16'(a), 16'(b), 16'(c), 16'(d)};
    endfunction

    task automatic clear();
        for (int i = 0; i < 16; i++) begin
            wr_addr[i] = 16'hDEAD;
            wr_data[i] = 32'hDEAD_DEAD;
        end
        wr_n   = 0;
        rd_n   = 0;
        rd_addr = 16'hDEAD;
        beat_n = 0;
        done_n = 0;
    endtask

    task automatic start_pass(input int dl, input int no, input int base,
                              input logic fp, input logic lp);
        cfg_dot_len    = 16'(dl);
        cfg_num_out    = 16'(no);
        cfg_base_addr  = 16'(base);
        cfg_first_pass = fp;
        cfg_last_pass  = lp;
        cfg_start      = 1'b1;
        tick();
        cfg_start      = 1'b0;
    endtask

    task automatic send_beat(input logic [63:0] ifm, input logic [63:0] w, input int gap);
        int t = 0;
        repeat (gap) begin
            bus.in_valid = 1'b0;
            tick();
        end
        bus.in_valid = 1'b1;
        bus.in_ifm   = ifm;
        bus.in_w     = w;
        while (!bus.in_ready && t < 200) begin
            tick();
            t++;
        end
        if (t >= 200) chk("beat_timeout", 64'(t), 64'd0);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (!done && t < 300) begin
            tick();
            t++;
        end
        chk({tag, "_done"}, 64'(done), 64'd1);
        tick();
        chk({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"},  64'(busy),             64'd0);
        chk({tag, "_done"},  64'(done),             64'd0);
        chk({tag, "_rdy"},   64'(bus.in_ready),     64'd0);
        chk({tag, "_ov"},    64'(bus.out_valid),    64'd0);
        chk({tag, "_rden"},  64'(bus.psum_rd_en),   64'd0);
        chk({tag, "_addr"},  64'(bus.out_addr),     64'd0);
        chk({tag, "_data"},  64'(bus.out_data),     64'd0);
    endtask

    initial begin
        int t;
        int beats_before;
        rst_n = 1'b0;
        cfg_start = 1'b0;
        cfg_dot_len = '0;
        cfg_num_out = '0;
        cfg_base_addr = '0;
        cfg_first_pass = 1'b0;
        cfg_last_pass = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_ifm = '0;
        bus.in_w = '0;
        bus.out_ready = 1'b1;
        psum_val = 32'd0;
        clear();
        repeat (3) tick();
        chk_quiet("rst");
        rst_n = 1'b1;
        tick();

        // T1: first pass, single beat 1+2+3+4
        clear();
        start_pass(1, 1, 'h10, 1'b1, 1'b0);
        send_beat(pack(1, 2, 3, 4), pack(1, 1, 1, 1), 0);
        wait_done("t1");
        chk("t1_nwr",  64'(wr_n), 64'd1);
        chk("t1_addr", 64'(wr_addr[0]), 64'h10);
        chk("t1_data", 64'(wr_data[0]), 64'd10);
        chk("t1_nrd",  64'(rd_n), 64'd0);

        // T2: psum fold-in 10 + 100
        clear();
        psum_val = 32'd100;
        start_pass(1, 1, 'h10, 1'b0, 1'b0);
        send_beat(pack(1, 2, 3, 4), pack(1, 1, 1, 1), 0);
        wait_done("t2");
        chk("t2_nrd",   64'(rd_n), 64'd1);
        chk("t2_rdadr", 64'(rd_addr), 64'h10);
        chk("t2_nwr",   64'(wr_n), 64'd1);
        chk("t2_data",  64'(wr_data[0]), 64'd110);

        // T3: 3 beats x 2 neurons, in_valid every other cycle
        clear();
        start_pass(3, 2, 0, 1'b1, 1'b0);
        send_beat(pack(1, 2, 3, 4),     pack(2, 2, 2, 2),    1);
        send_beat(pack(1, 0, 0, 0),     pack(5, 6, 7, 8),    1);
        send_beat(pack(-1, -1, -1, -1), pack(1, 1, 1, 1),    1);
        send_beat(pack(10, 0, 0, 0),    pack(10, 10, 10, 10), 1);
        send_beat(pack(0, 0, 0, 1),     pack(0, 0, 0, -3),   1);
        send_beat(pack(2, 2, 2, 2),     pack(3, 3, 3, 3),    1);
        wait_done("t3");
        chk("t3_beats", 64'(beat_n), 64'd6);
        chk("t3_nwr",   64'(wr_n), 64'd2);
        chk("t3_addr0", 64'(wr_addr[0]), 64'h0);
        chk("t3_data0", 64'(wr_data[0]), 64'd21);
        chk("t3_addr1", 64'(wr_addr[1]), 64'h1);
        chk("t3_data1", 64'(wr_data[1]), 64'd121);

        // T4: back-pressure, pending beat not consumed, restart ignored
        clear();
        bus.out_ready = 1'b0;
        start_pass(1, 1, 'h20, 1'b1, 1'b0);
        send_beat(pack(7, 0, 0, 0), pack(3, 3, 3, 3), 0);
        bus.in_valid = 1'b1;
        bus.in_ifm = pack(9, 9, 9, 9);
        bus.in_w = pack(9, 9, 9, 9);
        t = 0;
        while (!bus.out_valid && t < 50) begin
            tick();
            t++;
        end
        beats_before = beat_n;
        for (int i = 0; i < 5; i++) begin
            chk("t4_ov",   64'(bus.out_valid), 64'd1);
            chk("t4_addr", 64'(bus.out_addr),  64'h20);
            chk("t4_data", 64'(bus.out_data),  64'd21);
            chk("t4_rdy",  64'(bus.in_ready),  64'd0);
            if (i == 0) begin
                cfg_num_out = 16'd5;
                cfg_base_addr = 16'h30;
                cfg_start = 1'b1;
            end
            tick();
            cfg_start = 1'b0;
        end
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b0;
        wait_done("t4");
        chk("t4_beats", 64'(beat_n - beats_before), 64'd0);
        chk("t4_nwr",   64'(wr_n), 64'd1);
        chk("t4_waddr", 64'(wr_addr[0]), 64'h20);
        tick();
        chk("t4_norestart", 64'(busy), 64'd0);

        // Empty pass: done right after start
        clear();
        start_pass(1, 0, 'h50, 1'b1, 1'b0);
        chk("e_done", 64'(done), 64'd1);
        chk("e_busy", 64'(busy), 64'd1);
        tick();
        chk("e_idle", 64'(busy), 64'd0);
        chk("e_nwr",  64'(wr_n), 64'd0);

        // T5: -12 on last pass, dot_len 0 treated as 1
        clear();
        start_pass(0, 1, 'h30, 1'b1, 1'b1);
        send_beat(pack(-3, 0, 0, 0), pack(4, 0, 0, 0), 0);
        wait_done("t5");
        chk("t5_nwr", 64'(wr_n), 64'd1);
`ifdef CONV_MAC_RELU_EN
        chk("t5_data", 64'(wr_data[0]), 64'd0);
`else
        chk("t5_data", 64'(wr_data[0]), 64'hFFFF_FFF4);
`endif

        // T6: reset during neuron 1 accumulation, then a fresh pass
        clear();
        start_pass(2, 2, 'h40, 1'b1, 1'b0);
        send_beat(pack(1, 1, 1, 1), pack(1, 1, 1, 1), 0);
        send_beat(pack(1, 1, 1, 1), pack(1, 1, 1, 1), 0);
        send_beat(pack(5, 5, 5, 5), pack(5, 5, 5, 5), 0);
        rst_n = 1'b0;
        tick();
        chk_quiet("t6_rst");
        rst_n = 1'b1;
        repeat (4) tick();
        chk("t6_nwr",   64'(wr_n), 64'd1);
        chk("t6_addr",  64'(wr_addr[0]), 64'h40);
        chk("t6_data",  64'(wr_data[0]), 64'd8);
        chk("t6_nodone", 64'(done_n), 64'd0);
        clear();
        start_pass(1, 1, 'h5, 1'b1, 1'b0);
        send_beat(pack(1, 2, 3, 4), pack(1, 1, 1, 1), 0);
        wait_done("t6b");
        chk("t6b_nwr",  64'(wr_n), 64'd1);
        chk("t6b_addr", 64'(wr_addr[0]), 64'h5);
        chk("t6b_data", 64'(wr_data[0]), 64'd10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
